// File: rtl/wb_spi_slave.sv
// Wishbone-attached SPI mode-0 slave: 8-bit MSB-first frames, single-byte RX/TX
// holding registers, sticky status flags and a level interrupt. All SPI pins are oversampled.
module wb_spi_slave #(
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_sck_sync, r_mosi_sync, r_cs_sync;
  logic        r_ack;
  logic [31:0] r_dat_o;
  logic [2:0]  r_ctrl;
  logic        r_irq;
  logic [2:0]  r_bitcount;
  logic [7:0]  r_rx_shift, r_rx_data, r_tx_shift, r_tx_hold;
  logic        r_rx_full, r_tx_full, r_overrun, r_underrun;

  logic        w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_mosi;
  logic        w_start, w_abort, w_bit_rise, w_bit_fall, w_load, w_rx_done, w_busy;
  logic        w_req, w_rd_rx, w_wr_tx, w_wr_stat, w_wr_ctrl;
  logic [3:0]  w_reg;
  logic [31:0] w_rd_data;
  logic        w_unused;

  assign w_unused = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:8]};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync  <= 3'b000;
      r_mosi_sync <= 3'b000;
      r_cs_sync   <= 3'b111;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], spi_sck};
      r_mosi_sync <= {r_mosi_sync[1:0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[1:0], spi_cs_n};
    end
  end

  assign w_sck_rise =  r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall = ~r_sck_sync[1] &  r_sck_sync[2];
  assign w_cs_fall  = ~r_cs_sync[1]  &  r_cs_sync[2];
  assign w_cs_rise  =  r_cs_sync[1]  & ~r_cs_sync[2];
  assign w_mosi     =  r_mosi_sync[1];

  assign w_req     = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_reg     = wb_adr_i[5:2];
  assign w_rd_rx   = w_req & ~wb_we_i & (w_reg == 4'd0);
  assign w_wr_tx   = w_req &  wb_we_i & (w_reg == 4'd0);
  assign w_wr_stat = w_req &  wb_we_i & (w_reg == 4'd1);
  assign w_wr_ctrl = w_req &  wb_we_i & (w_reg == 4'd2);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE:
        if (w_cs_fall && r_ctrl[0]) begin
          w_state_nxt = ACTIVE;
          w_start     = 1'b1;
        end
      ACTIVE:
        if (w_cs_rise || !r_ctrl[0]) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A deselect wins over an sck edge seen in the same cycle, so a master may drop
  // sck and raise cs_n together without triggering a spurious reload.
  assign w_busy     = (r_state == ACTIVE);
  assign w_bit_rise = w_busy & ~w_abort & w_sck_rise;
  assign w_bit_fall = w_busy & ~w_abort & w_sck_fall;
  assign w_load     = w_start | (w_bit_fall & (r_bitcount == 3'd0));
  assign w_rx_done  = w_bit_rise & (r_bitcount == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitcount <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_full  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_start || w_abort) r_bitcount <= 3'd0;
      else if (w_bit_rise)    r_bitcount <= r_bitcount + 3'd1;
      if (w_bit_rise) r_rx_shift <= {r_rx_shift[6:0], w_mosi};
      if (w_wr_stat && wb_dat_i[2]) r_overrun <= 1'b0;
      if (w_rx_done) begin
        if (r_rx_full && !w_rd_rx) begin
          r_overrun <= 1'b1;
        end else begin
          r_rx_data <= {r_rx_shift[6:0], w_mosi};
          r_rx_full <= 1'b1;
        end
      end else if (w_rd_rx) begin
        r_rx_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_shift <= 8'h00;
      r_tx_hold  <= 8'h00;
      r_tx_full  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_wr_stat && wb_dat_i[5]) r_underrun <= 1'b0;
      if (w_load) begin
        if (r_tx_full) begin
          r_tx_shift <= r_tx_hold;
          r_tx_full  <= 1'b0;
        end else begin
          r_tx_shift <= FILL_BYTE;
          r_underrun <= 1'b1;
        end
      end else if (w_bit_fall) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
      // A write in the same cycle as a load is kept for the next load.
      if (w_wr_tx) begin
        r_tx_hold <= wb_dat_i[7:0];
        r_tx_full <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_data = 32'h0;
    case (w_reg)
      4'd0:    w_rd_data = {24'h0, r_rx_data};
      4'd1:    w_rd_data = {26'h0, r_underrun, w_busy, w_busy, r_overrun, r_tx_full, r_rx_full};
      4'd2:    w_rd_data = {29'h0, r_ctrl};
      default: w_rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack   <= 1'b0;
      r_dat_o <= 32'h0;
      r_ctrl  <= 3'b000;
      r_irq   <= 1'b0;
    end else begin
      r_ack <= wb_stb_i & wb_cyc_i & ~r_ack;
      if (w_req && !wb_we_i) r_dat_o <= w_rd_data;
      if (w_wr_ctrl) r_ctrl <= wb_dat_i[2:0];
      r_irq <= r_ctrl[0] & ((r_ctrl[1] & r_rx_full) | (r_ctrl[2] & ~r_tx_full));
    end
  end

  assign wb_dat_o    = r_dat_o;
  assign wb_ack_o    = wb_stb_i & wb_cyc_i & r_ack;
  assign spi_miso    = w_busy ? r_tx_shift[7] : 1'b1;
  assign spi_miso_oe = w_busy & r_ctrl[0];
  assign irq         = r_irq;

endmodule

// File: tb/tb_wb_spi_slave.sv
// Self-checking bench for wb_spi_slave: directed vector table, hand-written corner
// sequences, and a randomized phase against a frame-level model of the register file.
module tb_wb_spi_slave;

  localparam int HALF = 8;

  logic        clk, reset;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
  logic        spi_sck, spi_mosi, spi_cs_n, spi_miso, spi_miso_oe, irq;

  int total = 0;
  int bad   = 0;
  int irq_lat;
  logic oe_seen;

  wb_spi_slave #(.FILL_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] r, input logic [31:0] wd,
                         output logic [31:0] rd);
    logic got_ack;
    got_ack  = 1'b0;
    rd       = 32'h0;
    wb_adr_i = {26'h0, r, 2'b00};
    wb_dat_i = wd;
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    for (int t = 0; t < 8 && !got_ack; t++) begin
      wait_clk(1);
      if (wb_ack_o) begin
        got_ack = 1'b1;
        rd      = wb_dat_o;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    if (!got_ack) begin
      total++;
      bad++;
      $display("FAIL wb_ack_timeout: reg=%0d no ack within 8 cycles", r);
    end
  endtask

  task automatic wb_wr(input logic [3:0] r, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, r, d, dummy);
  endtask

  task automatic wb_rd(input logic [3:0] r, output logic [31:0] d);
    wb_xfer(1'b0, r, 32'h0, d);
  endtask

  // One chip-select session of nbytes; the last byte carries last_bits bits.
  // At the end, sck falls and cs_n rises together.
  task automatic spi_xfer(input int nbytes, input int last_bits, input logic [31:0] mosi_w,
                          output logic [31:0] miso_w);
    int nb;
    miso_w   = 32'h0;
    irq_lat  = 0;
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbytes; i++) begin
      nb = (i == nbytes - 1) ? last_bits : 8;
      for (int b = 0; b < nb; b++) begin
        spi_mosi = mosi_w[8*i + 7 - b];
        wait_clk(HALF);
        if (i == 0 && b == 0) oe_seen = spi_miso_oe;
        miso_w[8*i + 7 - b] = spi_miso;
        spi_sck = 1'b1;
        if (i == nbytes - 1 && b == nb - 1) begin
          for (int c = 1; c <= HALF; c++) begin
            wait_clk(1);
            if (irq && irq_lat == 0) irq_lat = c;
          end
          spi_sck  = 1'b0;
          spi_cs_n = 1'b1;
        end else begin
          wait_clk(HALF);
          spi_sck = 1'b0;
        end
      end
    end
    wait_clk(6);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_st;
    logic [7:0] exp_rx;
    logic [7:0] exp_st_after;
  } vec_t;

  vec_t vecs[4];

  // Frame-level model for the random phase.
  logic [7:0] m_rx_data, m_tx_hold;
  logic       m_rx_full, m_tx_full, m_ovr, m_udr;
  logic [2:0] m_ctrl;

  initial begin
    logic [31:0] rd, miso_w, mosi_w, exp_st;
    int n, op;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h01, 8'h3C, 8'h00};
    vecs[1] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'h01, 8'hFF, 8'h00};
    vecs[2] = '{1'b0, 8'h00, 8'h81, 8'hFF, 8'h21, 8'h81, 8'h20};
    vecs[3] = '{1'b1, 8'hC3, 8'h5A, 8'hC3, 8'h21, 8'h5A, 8'h20};

    reset = 1'b1;
    wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
    wait_clk(4);
    check("rst_dat_o", wb_dat_o, 32'h0);
    check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
    check("rst_miso", {31'h0, spi_miso}, 32'h1);
    check("rst_miso_oe", {31'h0, spi_miso_oe}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    wait_clk(2);
    wb_rd(4'd1, rd); check("rst_status", rd, 32'h0);
    wb_rd(4'd7, rd); check("unmapped_read", rd, 32'h0);
    wb_wr(4'd2, 32'h1);
    wb_rd(4'd2, rd); check("ctrl_readback", rd, 32'h1);

    // Directed single-frame vectors.
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].wr) wb_wr(4'd0, {24'h0, vecs[v].tx});
      spi_xfer(1, 8, {24'h0, vecs[v].mosi}, miso_w);
      check($sformatf("vec%0d_oe_in_frame", v), {31'h0, oe_seen}, 32'h1);
      check($sformatf("vec%0d_miso", v), miso_w[7:0], vecs[v].exp_miso);
      check($sformatf("vec%0d_oe_idle", v), {31'h0, spi_miso_oe}, 32'h0);
      wb_rd(4'd1, rd); check($sformatf("vec%0d_status", v), rd, {24'h0, vecs[v].exp_st});
      wb_rd(4'd0, rd); check($sformatf("vec%0d_rxdata", v), rd, {24'h0, vecs[v].exp_rx});
      wb_rd(4'd1, rd); check($sformatf("vec%0d_status_after", v), rd, {24'h0, vecs[v].exp_st_after});
    end

    // Back-to-back frames with one TX byte: underrun then overrun; clear both flags.
    wb_wr(4'd1, 32'h24);
    wb_rd(4'd1, rd); check("b2b_status_pre", rd, 32'h0);
    wb_wr(4'd0, 32'h5A);
    spi_xfer(2, 8, 32'h0000_2211, miso_w);
    check("b2b_miso0", miso_w[7:0], 32'h5A);
    check("b2b_miso1", miso_w[15:8], 32'hFF);
    wb_rd(4'd1, rd); check("b2b_status", rd, 32'h25);
    wb_wr(4'd1, 32'h24);
    wb_rd(4'd1, rd); check("flag_clear_status", rd, 32'h01);
    wb_rd(4'd0, rd); check("b2b_rxdata", rd, 32'h11);

    // Partial frame aborted by cs_n, then a full frame.
    wb_wr(4'd0, 32'h77);
    spi_xfer(1, 4, 32'h0000_00F0, miso_w);
    wb_rd(4'd1, rd); check("abort_status", rd, 32'h0);
    spi_xfer(1, 8, 32'h0000_0081, miso_w);
    wb_rd(4'd0, rd); check("after_abort_rxdata", rd, 32'h81);
    wb_wr(4'd1, 32'h20);

    // RX interrupt latency and clear, then TX-empty interrupt.
    wb_wr(4'd2, 32'h3);
    wait_clk(2);
    check("irq_idle", {31'h0, irq}, 32'h0);
    spi_xfer(1, 8, 32'h0000_0042, miso_w);
    check("irq_latency_ok", {31'h0, (irq_lat >= 1 && irq_lat <= 5)}, 32'h1);
    wb_rd(4'd0, rd); check("irq_rxdata", rd, 32'h42);
    wait_clk(1);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    wb_wr(4'd2, 32'h5);
    wait_clk(2);
    check("irq_tx_empty", {31'h0, irq}, 32'h1);
    wb_wr(4'd0, 32'h10);
    wait_clk(2);
    check("irq_tx_filled", {31'h0, irq}, 32'h0);

    // Reset in the middle of a frame.
    wb_wr(4'd2, 32'h1);
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int b = 0; b < 3; b++) begin
      spi_mosi = b[0];
      wait_clk(HALF);
      spi_sck = 1'b1;
      wait_clk(HALF);
      if (b < 2) spi_sck = 1'b0;
    end
    check("midframe_oe", {31'h0, spi_miso_oe}, 32'h1);
    reset = 1'b1;
    wait_clk(2);
    check("rst_mid_oe", {31'h0, spi_miso_oe}, 32'h0);
    check("rst_mid_miso", {31'h0, spi_miso}, 32'h1);
    reset = 1'b0;
    spi_sck = 1'b0;
    spi_cs_n = 1'b1;
    wait_clk(6);
    wb_rd(4'd1, rd); check("rst_mid_status", rd, 32'h0);
    wb_rd(4'd2, rd); check("rst_mid_ctrl", rd, 32'h0);
    wb_wr(4'd2, 32'h1);
    spi_xfer(1, 8, 32'h0000_005C, miso_w);
    wb_rd(4'd0, rd); check("rst_mid_next_rx", rd, 32'h5C);

    // Randomized phase against the frame-level model.
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(2);
    m_rx_data = 8'h0; m_tx_hold = 8'h0; m_rx_full = 1'b0; m_tx_full = 1'b0;
    m_ovr = 1'b0; m_udr = 1'b0; m_ctrl = 3'b001;
    wb_wr(4'd2, 32'h1);
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          m_tx_hold = 8'($urandom);
          m_tx_full = 1'b1;
          wb_wr(4'd0, {24'h0, m_tx_hold});
        end
        1: begin
          n = $urandom_range(1, 3);
          mosi_w = $urandom;
          spi_xfer(n, 8, mosi_w, miso_w);
          for (int i = 0; i < n; i++) begin
            logic [7:0] exp_m;
            if (!m_ctrl[0]) begin
              exp_m = 8'hFF;
            end else begin
              if (m_tx_full) begin
                exp_m = m_tx_hold;
                m_tx_full = 1'b0;
              end else begin
                exp_m = 8'hFF;
                m_udr = 1'b1;
              end
              if (m_rx_full) m_ovr = 1'b1;
              else begin
                m_rx_data = mosi_w[8*i +: 8];
                m_rx_full = 1'b1;
              end
            end
            check($sformatf("rnd%0d_miso%0d", it, i), miso_w[8*i +: 8], exp_m);
          end
        end
        2: begin
          wb_rd(4'd0, rd);
          check($sformatf("rnd%0d_rxdata", it), rd, {24'h0, m_rx_data});
          m_rx_full = 1'b0;
        end
        3: begin
          wb_rd(4'd1, rd);
          exp_st = {26'h0, m_udr, 2'b00, m_ovr, m_tx_full, m_rx_full};
          check($sformatf("rnd%0d_status", it), rd, exp_st);
        end
        4: begin
          rd = $urandom;
          wb_wr(4'd1, rd);
          if (rd[2]) m_ovr = 1'b0;
          if (rd[5]) m_udr = 1'b0;
        end
        default: begin
          m_ctrl = 3'($urandom_range(0, 7));
          if ($urandom_range(0, 3) != 0) m_ctrl[0] = 1'b1;
          wb_wr(4'd2, {29'h0, m_ctrl});
        end
      endcase
      wait_clk(2);
      check($sformatf("rnd%0d_irq", it), {31'h0, irq},
            {31'h0, m_ctrl[0] & ((m_ctrl[1] & m_rx_full) | (m_ctrl[2] & ~m_tx_full))});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
